tag_lookup_ctrl: RTL

TAG_LOOKUP_CTRL -- requirements
Module: tag_lookup_ctrl

---
 rtl/tag_lookup_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/tag_lookup_ctrl.sv
// tag_lookup_ctrl
//   Lookup/allocate controller in front of a synchronous-read tag RAM.
//   A request reads the entry at req_index, compares {valid, tag} against
//   req_tag, and on a miss with req_alloc writes {1, req_tag} back. A flush
//   walks every index and writes zero, invalidating the whole array.
//
// Ports
//   clock, reset_n          : clock and asynchronous active-low reset
//   req_valid/ready         : request handshake; req_index, req_tag, req_alloc
//   flush                   : invalidate all entries (honoured only in IDLE)
//   resp_valid/ready        : response handshake; resp_hit carries the result
//   busy                    : controller is not IDLE
//   ram_addr/din/we/dout    : tag RAM port; dout is valid the cycle after addr
//
// state   | meaning
// IDLE    | waiting for a request or a flush
// ISSUE   | latched index on ram_addr, RAM registers it
// COMPARE | ram_dout valid, evaluate hit
// FILL    | one-cycle write of {1, tag} after an allocating miss
// RESP    | resp_valid held until resp_ready
// FLUSH   | write zero at counter, one entry per cycle

module tag_lookup_ctrl #(
   parameter  int AWIDTH = 3,
   parameter  int TWIDTH = 6,
   localparam int DWIDTH = TWIDTH + 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [AWIDTH-1:0] req_index,
   input  logic [TWIDTH-1:0] req_tag,
   input  logic              req_alloc,
   input  logic              flush,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_hit,
   output logic              busy,
   output logic [AWIDTH-1:0] ram_addr,
   output logic [DWIDTH-1:0] ram_din,
   output logic              ram_we,
   input  logic [DWIDTH-1:0] ram_dout
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ISSUE   = 3'd1;
   localparam logic [2:0] ST_COMPARE = 3'd2;
   localparam logic [2:0] ST_FILL    = 3'd3;
   localparam logic [2:0] ST_RESP    = 3'd4;
   localparam logic [2:0] ST_FLUSH   = 3'd5;

   logic [2:0]        state_q, state_d;
   logic [AWIDTH-1:0] idx_q, idx_d;
   logic [TWIDTH-1:0] tag_q, tag_d;
   logic              alloc_q, alloc_d;
   logic              hit_q, hit_d;
   logic [AWIDTH-1:0] cnt_q, cnt_d;
   logic              hit_now;

   assign hit_now = ram_dout[TWIDTH] && (ram_dout[TWIDTH-1:0] == tag_q);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      tag_d   = tag_q;
      alloc_d = alloc_q;
      hit_d   = hit_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            // flush wins over a simultaneous request
            if (flush) begin
               state_d = ST_FLUSH;
               cnt_d   = '0;
            end else if (req_valid) begin
               state_d = ST_ISSUE;
               idx_d   = req_index;
               tag_d   = req_tag;
               alloc_d = req_alloc;
               hit_d   = 1'b0;
            end
         end
         ST_ISSUE: state_d = ST_COMPARE;
         ST_COMPARE: begin
            hit_d   = hit_now;
            state_d = (!hit_now && alloc_q) ? ST_FILL : ST_RESP;
         end
         ST_FILL: state_d = ST_RESP;
         ST_RESP: begin
            if (resp_ready) state_d = ST_IDLE;
         end
         ST_FLUSH: begin
            cnt_d = cnt_q + 1'b1;
            // all-ones counter is the last entry
            if (&cnt_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         tag_q   <= '0;
         alloc_q <= 1'b0;
         hit_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tag_q   <= tag_d;
         alloc_q <= alloc_d;
         hit_q   <= hit_d;
         cnt_q   <= cnt_d;
      end
   end

   // RAM port decodes only from state and latched fields, so reset
   // forces it quiet immediately.
   always_comb begin
      ram_we   = (state_q == ST_FILL) || (state_q == ST_FLUSH);
      ram_addr = '0;
      ram_din  = '0;
      if (state_q == ST_FLUSH) begin
         ram_addr = cnt_q;
      end else if ((state_q == ST_ISSUE) || (state_q == ST_FILL)) begin
         ram_addr = idx_q;
      end
      if (state_q == ST_FILL) ram_din = {1'b1, tag_q};
   end

   assign req_ready  = (state_q == ST_IDLE) && !flush;
   assign resp_valid = (state_q == ST_RESP);
   assign resp_hit   = hit_q;
   assign busy       = (state_q != ST_IDLE);

endmodule
